// File: rtl/decode_writeback_pkg.sv
// Shared constants for the decode/writeback end of the 8-bit multicycle MIPS-subset core:
// phase codes, opcodes, funcs, instruction field positions and the writeback selector.
package decode_writeback_pkg;

    localparam int DATA_W     = 8;
    localparam int NREG       = 32;
    localparam int REG_AW     = 5;
    localparam int DMEM_DEPTH = 16;
    localparam int DMEM_AW    = 4;

    localparam logic [2:0] STATE_IF  = 3'd0;
    localparam logic [2:0] STATE_ID  = 3'd1;
    localparam logic [2:0] STATE_EX  = 3'd2;
    localparam logic [2:0] STATE_MEM = 3'd3;
    localparam logic [2:0] STATE_WB  = 3'd4;

    localparam logic [5:0] OP_RFORM = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h17;

    localparam logic [5:0] FUNC_JR   = 6'h08;
    localparam logic [5:0] FUNC_ADDU = 6'h21;
    localparam logic [5:0] FUNC_SLT  = 6'h2a;

    localparam int OP_MSB = 31, OP_LSB = 26;
    localparam int RS_MSB = 25, RS_LSB = 21;
    localparam int RT_MSB = 20, RT_LSB = 16;
    localparam int RD_MSB = 15, RD_LSB = 11;
    localparam int FN_MSB = 5,  FN_LSB = 0;
    localparam int IMM_MSB = 15;
    localparam int JT_MSB  = 25;

    localparam logic [REG_AW-1:0] REG_RA = 5'd31;

    typedef struct packed {
        logic              en;
        logic              use_load;
        logic [REG_AW-1:0] dest;
    } wb_sel_t;

    // Destination register and value source for the instruction being retired.
    function automatic wb_sel_t wb_select(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd);
        wb_sel_t s;
        s = '0;
        case (op)
            OP_RFORM: begin
                if (fn == FUNC_ADDU || fn == FUNC_SLT) begin
                    s.en   = 1'b1;
                    s.dest = rd;
                end else begin
                    s.en   = 1'b0;
                end
            end
            OP_ADDIU: begin
                s.en   = 1'b1;
                s.dest = rt;
            end
            OP_LW: begin
                s.en       = 1'b1;
                s.use_load = 1'b1;
                s.dest     = rt;
            end
            OP_JAL: begin
                s.en   = 1'b1;
                s.dest = REG_RA;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/decode_writeback_regfile_2r1w.sv
// 32x8 register file: two read ports latched on rd_en, one write port, reg0 hardwired to zero,
// plus a combinational debug read.
module regfile_2r1w
    import decode_writeback_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] rsv,
    output logic [DATA_W-1:0] rtv,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_r [NREG];

    // Register array write; reg0 is never written so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (we && wa != 5'd0) begin
            regs_r[wa] <= wd;
        end
    end

    // Read-port latches, captured in ID and held until the next ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsv <= 8'h00;
            rtv <= 8'h00;
        end else if (rd_en) begin
            rsv <= (rs_addr == 5'd0) ? 8'h00 : regs_r[rs_addr];
            rtv <= (rt_addr == 5'd0) ? 8'h00 : regs_r[rt_addr];
        end
    end

    assign dbg_data = (dbg_sel == 5'd0) ? 8'h00 : regs_r[dbg_sel];

endmodule

// File: rtl/decode_writeback.sv
// ID/MEM/WB side of the multicycle core: instruction decode with register reads, data-memory
// load with range checking, and register writeback of execute results or loaded data.
module decode_writeback
    import decode_writeback_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  state,
    input  logic [31:0] instruction,
    input  logic [7:0]  result,
    input  logic [7:0]  data_addr,
    input  logic        instruction_invalid,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [15:0] imm,
    output logic [25:0] jump_target,
    output logic [7:0]  rsv,
    output logic [7:0]  rtv,
    input  logic        host_we,
    input  logic [7:0]  host_addr,
    input  logic [7:0]  host_wdata,
    input  logic [4:0]  dbg_reg,
    output logic [7:0]  dbg_data,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [7:0]  wb_data,
    output logic        addr_error
);

    localparam logic [7:0] DMEM_LIMIT = 8'(DMEM_DEPTH);

    logic [REG_AW-1:0] rt_r, rd_r;
    logic [DATA_W-1:0] dmem_r [DMEM_DEPTH];
    logic [DATA_W-1:0] load_q_r;
    wb_sel_t           wb_sel_s;
    logic              commit_s;
    logic [DATA_W-1:0] wb_value_s;
    logic              id_s;

    assign id_s = (state == STATE_ID);

    // Instruction field latches, refreshed only in ID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode      <= 6'h00;
            func        <= 6'h00;
            imm         <= 16'h0000;
            jump_target <= 26'h0;
            rt_r        <= 5'd0;
            rd_r        <= 5'd0;
        end else if (id_s) begin
            opcode      <= instruction[OP_MSB:OP_LSB];
            func        <= instruction[FN_MSB:FN_LSB];
            imm         <= instruction[IMM_MSB:0];
            jump_target <= instruction[JT_MSB:0];
            rt_r        <= instruction[RT_MSB:RT_LSB];
            rd_r        <= instruction[RD_MSB:RD_LSB];
        end
    end

    // Host preload port; out-of-range addresses are dropped rather than aliased.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem_r[i] <= 8'h00;
            end
        end else if (host_we && host_addr < DMEM_LIMIT) begin
            dmem_r[host_addr[DMEM_AW-1:0]] <= host_wdata;
        end
    end

    // MEM-phase load; reads the pre-write word when a host write hits the same address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_q_r   <= 8'h00;
            addr_error <= 1'b0;
        end else if (state == STATE_MEM && opcode == OP_LW && !instruction_invalid) begin
            if (data_addr < DMEM_LIMIT) begin
                load_q_r <= dmem_r[data_addr[DMEM_AW-1:0]];
            end else begin
                load_q_r   <= 8'h00;
                addr_error <= 1'b1;
            end
        end
    end

    // Writeback decision for the current WB phase.
    always_comb begin
        wb_sel_s   = wb_select(opcode, func, rt_r, rd_r);
        wb_value_s = wb_sel_s.use_load ? load_q_r : result;
        commit_s   = 1'b0;
        if (state == STATE_WB && !instruction_invalid && wb_sel_s.en && wb_sel_s.dest != 5'd0) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Writeback status: wb_en is a one-cycle pulse, reg/data hold the last committed write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en   <= 1'b0;
            wb_reg  <= 5'd0;
            wb_data <= 8'h00;
        end else begin
            wb_en <= commit_s;
            if (commit_s) begin
                wb_reg  <= wb_sel_s.dest;
                wb_data <= wb_value_s;
            end
        end
    end

    regfile_2r1w u_regfile (
        .clk      (clk),
        .rst      (reset),
        .rd_en    (id_s),
        .rs_addr  (instruction[RS_MSB:RS_LSB]),
        .rt_addr  (instruction[RT_MSB:RT_LSB]),
        .we       (commit_s),
        .wa       (wb_sel_s.dest),
        .wd       (wb_value_s),
        .dbg_sel  (dbg_reg),
        .rsv      (rsv),
        .rtv      (rtv),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_decode_writeback.sv
// Directed table-driven bench for decode_writeback: each vector walks one instruction through
// IF..WB; hand-written sequences cover preload, reset values and reset between MEM and WB.
module tb_decode_writeback;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  state;
    logic [31:0] instruction;
    logic [7:0]  result, data_addr;
    logic        instruction_invalid;
    logic [5:0]  opcode, func;
    logic [15:0] imm;
    logic [25:0] jump_target;
    logic [7:0]  rsv, rtv;
    logic        host_we;
    logic [7:0]  host_addr, host_wdata;
    logic [4:0]  dbg_reg;
    logic [7:0]  dbg_data;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [7:0]  wb_data;
    logic        addr_error;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_writeback dut (
        .clk(clk), .reset(reset), .state(state), .instruction(instruction),
        .result(result), .data_addr(data_addr), .instruction_invalid(instruction_invalid),
        .opcode(opcode), .func(func), .imm(imm), .jump_target(jump_target),
        .rsv(rsv), .rtv(rtv), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .dbg_reg(dbg_reg), .dbg_data(dbg_data),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .addr_error(addr_error)
    );

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  res;
        logic [7:0]  daddr;
        logic        inval;
        logic        hw_en;
        logic [7:0]  hw_addr;
        logic [7:0]  hw_data;
        logic [5:0]  e_op;
        logic [5:0]  e_func;
        logic [7:0]  e_rsv;
        logic [7:0]  e_rtv;
        logic        e_en;
        logic [4:0]  e_reg;
        logic [7:0]  e_data;
        logic [4:0]  c_reg;
        logic [7:0]  c_val;
        logic        e_aerr;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] st);
        state = st;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        instruction         = v.instr;
        result              = v.res;
        data_addr           = v.daddr;
        instruction_invalid = v.inval;
        step(S_IF);
        check($sformatf("v%0d_wb_en_cleared", i), {31'd0, wb_en}, 32'd0);
        step(S_ID);
        check($sformatf("v%0d_opcode", i), {26'd0, opcode}, {26'd0, v.e_op});
        check($sformatf("v%0d_func", i),   {26'd0, func},   {26'd0, v.e_func});
        check($sformatf("v%0d_rsv", i),    {24'd0, rsv},    {24'd0, v.e_rsv});
        check($sformatf("v%0d_rtv", i),    {24'd0, rtv},    {24'd0, v.e_rtv});
        step(S_EX);
        host_we    = v.hw_en;
        host_addr  = v.hw_addr;
        host_wdata = v.hw_data;
        step(S_MEM);
        host_we = 1'b0;
        step(S_WB);
        check($sformatf("v%0d_wb_en", i),   {31'd0, wb_en},  {31'd0, v.e_en});
        check($sformatf("v%0d_wb_reg", i),  {27'd0, wb_reg}, {27'd0, v.e_reg});
        check($sformatf("v%0d_wb_data", i), {24'd0, wb_data}, {24'd0, v.e_data});
        check($sformatf("v%0d_addr_error", i), {31'd0, addr_error}, {31'd0, v.e_aerr});
        dbg_reg = v.c_reg;
        #1;
        check($sformatf("v%0d_reg%0d", i, v.c_reg), {24'd0, dbg_data}, {24'd0, v.c_val});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pre_addr [4];
        logic [7:0] pre_data [4];

        //         instr         res    da     iv    hw    ha     hd     op     fn     rsv    rtv    en    reg    data   creg   cval   aerr
        vecs[0]  = '{32'h24010005, 8'd5,  8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  6'h09, 6'h05, 8'd0,  8'd0,  1'b1, 5'd1,  8'd5,  5'd1,  8'd5,  1'b0};
        vecs[1]  = '{32'h24030007, 8'd7,  8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  6'h09, 6'h07, 8'd0,  8'd0,  1'b1, 5'd3,  8'd7,  5'd3,  8'd7,  1'b0};
        vecs[2]  = '{32'h2405000A, 8'd10, 8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  6'h09, 6'h0A, 8'd0,  8'd0,  1'b1, 5'd5,  8'd10, 5'd5,  8'd10, 1'b0};
        vecs[3]  = '{32'h24000009, 8'd9,  8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  6'h09, 6'h09, 8'd0,  8'd0,  1'b0, 5'd5,  8'd10, 5'd0,  8'd0,  1'b0};
        vecs[4]  = '{32'h24070003, 8'd3,  8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  6'h09, 6'h03, 8'd0,  8'd0,  1'b1, 5'd7,  8'd3,  5'd7,  8'd3,  1'b0};
        vecs[5]  = '{32'h0C000010, 8'd14, 8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  6'h03, 6'h10, 8'd0,  8'd0,  1'b1, 5'd31, 8'd14, 5'd31, 8'd14, 1'b0};
        vecs[6]  = '{32'h10230004, 8'h55, 8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  6'h04, 6'h04, 8'd5,  8'd7,  1'b0, 5'd31, 8'd14, 5'd1,  8'd5,  1'b0};
        vecs[7]  = '{32'h00232021, 8'd99, 8'd0,  1'b1, 1'b0, 8'd0,  8'd0,  6'h00, 6'h21, 8'd5,  8'd7,  1'b0, 5'd31, 8'd14, 5'd4,  8'd0,  1'b0};
        vecs[8]  = '{32'h0023402A, 8'd1,  8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  6'h00, 6'h2A, 8'd5,  8'd7,  1'b1, 5'd8,  8'd1,  5'd8,  8'd1,  1'b0};
        vecs[9]  = '{32'h03E00008, 8'd33, 8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  6'h00, 6'h08, 8'd14, 8'd0,  1'b0, 5'd8,  8'd1,  5'd31, 8'd14, 1'b0};
        vecs[10] = '{32'h14230002, 8'd44, 8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  6'h05, 6'h02, 8'd5,  8'd7,  1'b0, 5'd8,  8'd1,  5'd3,  8'd7,  1'b0};
        vecs[11] = '{32'h00231021, 8'd12, 8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  6'h00, 6'h21, 8'd5,  8'd7,  1'b1, 5'd2,  8'd12, 5'd2,  8'd12, 1'b0};
        vecs[12] = '{32'h5C01000A, 8'd0,  8'd10, 1'b0, 1'b0, 8'd0,  8'd0,  6'h17, 6'h0A, 8'd0,  8'd5,  1'b1, 5'd1,  8'd42, 5'd1,  8'd42, 1'b0};
        vecs[13] = '{32'h5C09000F, 8'd0,  8'd15, 1'b0, 1'b0, 8'd0,  8'd0,  6'h17, 6'h0F, 8'd0,  8'd0,  1'b1, 5'd9,  8'd77, 5'd9,  8'd77, 1'b0};
        vecs[14] = '{32'h5C0C0000, 8'd0,  8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  6'h17, 6'h00, 8'd0,  8'd0,  1'b1, 5'd12, 8'd0,  5'd12, 8'd0,  1'b0};
        vecs[15] = '{32'h5C070014, 8'd0,  8'd20, 1'b0, 1'b0, 8'd0,  8'd0,  6'h17, 6'h14, 8'd0,  8'd3,  1'b1, 5'd7,  8'd0,  5'd7,  8'd0,  1'b1};
        vecs[16] = '{32'h240D0001, 8'd1,  8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  6'h09, 6'h01, 8'd0,  8'd0,  1'b1, 5'd13, 8'd1,  5'd13, 8'd1,  1'b1};
        vecs[17] = '{32'h5C0A000C, 8'd0,  8'd12, 1'b0, 1'b1, 8'd12, 8'd55, 6'h17, 6'h0C, 8'd0,  8'd0,  1'b1, 5'd10, 8'd33, 5'd10, 8'd33, 1'b1};
        vecs[18] = '{32'h5C0B000C, 8'd0,  8'd12, 1'b0, 1'b0, 8'd0,  8'd0,  6'h17, 6'h0C, 8'd0,  8'd0,  1'b1, 5'd11, 8'd55, 5'd11, 8'd55, 1'b1};

        // Address 16 is out of range; a write that aliased onto word 0 would show up in vecs[14].
        pre_addr = '{8'd10, 8'd15, 8'd12, 8'd16};
        pre_data = '{8'd42, 8'd77, 8'd33, 8'd99};

        reset = 1'b1;
        state = S_IF;
        instruction = 32'h0;
        result = 8'h00;
        data_addr = 8'h00;
        instruction_invalid = 1'b0;
        host_we = 1'b0;
        host_addr = 8'h00;
        host_wdata = 8'h00;
        dbg_reg = 5'd31;
        repeat (2) @(negedge clk);
        check("rst_opcode", {26'd0, opcode}, 32'd0);
        check("rst_rsv", {24'd0, rsv}, 32'd0);
        check("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("rst_addr_error", {31'd0, addr_error}, 32'd0);
        check("rst_reg31", {24'd0, dbg_data}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            host_we    = 1'b1;
            host_addr  = pre_addr[i];
            host_wdata = pre_data[i];
            step(S_IF);
        end
        host_we = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_vec(i, vecs[i]);
        end

        // lw $6,10($0): reset asserted between MEM and WB.
        instruction = 32'h5C06000A;
        data_addr   = 8'd10;
        result      = 8'h00;
        step(S_IF);
        step(S_ID);
        check("rst_seq_imm", {16'd0, imm}, 32'h0000000A);
        check("rst_seq_jt", {6'd0, jump_target}, 32'h0006000A);
        step(S_EX);
        step(S_MEM);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_opcode", {26'd0, opcode}, 32'd0);
        check("rst_async_imm", {16'd0, imm}, 32'd0);
        check("rst_async_wb_reg", {27'd0, wb_reg}, 32'd0);
        check("rst_async_wb_data", {24'd0, wb_data}, 32'd0);
        check("rst_async_addr_error", {31'd0, addr_error}, 32'd0);
        dbg_reg = 5'd1;
        #1;
        check("rst_async_reg1", {24'd0, dbg_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(S_WB);
        check("rst_wb_en_after", {31'd0, wb_en}, 32'd0);
        dbg_reg = 5'd6;
        #1;
        check("rst_reg6", {24'd0, dbg_data}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
